// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared state encoding and constants for the CPU bus master
package cpu_bus_pkg;

    localparam int BUS_ADDR_W           = 16;
    localparam int BUS_DATA_W           = 8;
    localparam int DEFAULT_WAIT_TIMEOUT = 15;
    localparam logic [7:0] OPEN_BUS_DATA = 8'hFF;

    typedef enum logic [2:0] {IDLE, T1, T2, TW, T3, T4} state_t;

endpackage

// File: rtl/cpu_bus_master_if.sv
// cpu_bus_master_if: core request/response and system bus signals of the CPU bus master
interface cpu_bus_master_if
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_rd_n;
    logic              bus_wr_n;
    logic              bus_wait_n;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, bus_rdata, bus_wait_n,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
               bus_addr, bus_wdata, bus_rd_n, bus_wr_n
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, bus_rdata, bus_wait_n,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
               bus_addr, bus_wdata, bus_rd_n, bus_wr_n
    );

endinterface

// File: rtl/cpu_bus_master_wait_timer.sv
// bus_wait_timer: saturating wait-state counter with clear/enable and a timeout flag
module bus_wait_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_timeout
);

    localparam int W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [W-1:0] MAX = (LIMIT > 0) ? W'(LIMIT) : {W{1'b1}};

    logic [W-1:0] r_count;

    // count wait cycles, holding at MAX so the value can never wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_count <= '0;
        else if (i_clear)
            r_count <= '0;
        else if (i_en && r_count != MAX)
            r_count <= r_count + 1'b1;
    end

    assign o_timeout = (LIMIT != 0) && (r_count == W'(LIMIT - 1));

endmodule

// File: rtl/cpu_bus_master.sv
// cpu_bus_master: turns single-beat core requests into Game Boy style T1/T2/TW/T3/T4 bus cycles
module cpu_bus_master
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W       = BUS_ADDR_W,
    parameter int DATA_W       = BUS_DATA_W,
    parameter int WAIT_TIMEOUT = DEFAULT_WAIT_TIMEOUT
) (
    input logic               clk,
    input logic               rst_n,
    cpu_bus_master_if.master  bus
);

    state_t            r_state;
    logic              r_we;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rd_n;
    logic              r_wr_n;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic              r_busy;
    logic              r_req_ready;
    logic              w_timeout;

    bus_wait_timer #(.LIMIT(WAIT_TIMEOUT)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (r_state == T2),
        .i_en      (r_state == TW),
        .o_timeout (w_timeout)
    );

    // machine-cycle FSM; every output is a register so the bus sees clean edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_rd_n      <= 1'b1;
            r_wr_n      <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_req_ready <= 1'b1;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            case (r_state)
                IDLE: if (bus.req_valid) begin
                    r_we        <= bus.req_we;
                    r_err       <= 1'b0;
                    r_addr      <= bus.req_addr;
                    r_wdata     <= bus.req_wdata;
                    r_req_ready <= 1'b0;
                    r_busy      <= 1'b1;
                    r_state     <= T1;
                end
                T1: begin
                    r_rd_n  <= r_we;
                    r_wr_n  <= !r_we;
                    r_state <= T2;
                end
                T2, TW: if (bus.bus_wait_n) begin
                    r_rd_n  <= 1'b1;
                    r_wr_n  <= 1'b1;
                    r_rdata <= r_we ? r_rdata : bus.bus_rdata;
                    r_state <= T3;
                end else if (r_state == T2) begin
                    r_state <= TW;
                end else if (w_timeout) begin
                    r_rd_n      <= 1'b1;
                    r_wr_n      <= 1'b1;
                    r_err       <= 1'b1;
                    r_rdata     <= r_we ? r_rdata : DATA_W'(OPEN_BUS_DATA);
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b1;
                    r_state     <= T4;
                end
                T3: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= r_err;
                    r_state     <= T4;
                end
                T4: begin
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.busy      = r_busy;
    assign bus.bus_addr  = r_addr;
    assign bus.bus_wdata = r_wdata;
    assign bus.bus_rd_n  = r_rd_n;
    assign bus.bus_wr_n  = r_wr_n;

endmodule

// File: tb/tb_cpu_bus_master.sv
// tb_cpu_bus_master: scoreboard bench with a wait-state responder for cpu_bus_master
module tb_cpu_bus_master;
    import cpu_bus_pkg::*;

    localparam int TO = 15;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rd_in;
        int          n;
        logic [7:0]  rdata;
        logic        err;
        int          lat;
        int          strobes;
    } item_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    item_t q[$];
    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int sc = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int a1, a2;
    bit will_accept = 1'b0;
    logic [7:0] model_rdata = 8'h00;

    always #5 clk = ~clk;

    cpu_bus_master_if #(.ADDR_W(16), .DATA_W(8)) bif ();

    cpu_bus_master #(.ADDR_W(16), .DATA_W(8), .WAIT_TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.master)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // responder: holds wait_n low for the first n strobe cycles of the current access
    always @(posedge clk) begin
        #2;
        sc = (bif.bus_rd_n && bif.bus_wr_n) ? 0 : sc + 1;
        bif.bus_wait_n = (q.size() == 0) || (sc > q[0].n);
        bif.bus_rdata = (q.size() == 0) ? 8'h00 : q[0].rd_in;
    end

    // monitor: per-cycle invariants, strobe accounting and response scoreboard
    always @(negedge clk) begin
        cyc++;
        will_accept = rst_n && bif.req_valid && bif.req_ready;
        if (will_accept) acc_cyc = cyc;
        if (!rst_n) begin
            rd_cnt = 0;
            wr_cnt = 0;
        end else begin
            check("one_strobe", {31'd0, bif.bus_rd_n | bif.bus_wr_n}, 1);
            check("ready_vs_busy", {31'd0, bif.req_ready}, {31'd0, !bif.busy});
            if (!bif.bus_rd_n || !bif.bus_wr_n) begin
                if (rd_cnt + wr_cnt == 0 && q.size() > 0) begin
                    check("bus_addr", {16'd0, bif.bus_addr}, {16'd0, q[0].addr});
                    if (q[0].we) check("bus_wdata", {24'd0, bif.bus_wdata}, {24'd0, q[0].wdata});
                end
                if (!bif.bus_rd_n) rd_cnt++;
                if (!bif.bus_wr_n) wr_cnt++;
            end
            if (bif.rsp_valid) begin
                if (q.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    item_t it;
                    it = q.pop_front();
                    check("rsp_lat", cyc - acc_cyc, it.lat);
                    check("rsp_rdata", {24'd0, bif.rsp_rdata}, {24'd0, it.rdata});
                    check("rsp_err", {31'd0, bif.rsp_err}, {31'd0, it.err});
                    check("rd_strobes", rd_cnt, it.we ? 0 : it.strobes);
                    check("wr_strobes", wr_cnt, it.we ? it.strobes : 0);
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    task automatic issue(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                         input logic [7:0] rd, input int n, input bit hold, output int acc);
        item_t it;
        int tw;
        it.err = (n > TO);
        tw = it.err ? TO : n;
        it.we = we;
        it.addr = addr;
        it.wdata = wd;
        it.rd_in = rd;
        it.n = n;
        it.lat = it.err ? 4 + TO - 1 : 4 + tw;
        it.strobes = 1 + tw;
        it.rdata = we ? model_rdata : (it.err ? 8'hFF : rd);
        model_rdata = it.rdata;
        q.push_back(it);
        bif.req_we = we;
        bif.req_addr = addr;
        bif.req_wdata = wd;
        bif.req_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 100 && acc < 0; i++) begin
            @(posedge clk);
            if (will_accept) acc = acc_cyc;
        end
        if (acc < 0) check("accept_timeout", 0, 1);
        #1;
        if (!hold) bif.req_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) check("done_timeout", 0, 1);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bif.req_valid = 1'b0;
        bif.req_we = 1'b0;
        bif.req_addr = 16'h0000;
        bif.req_wdata = 8'h00;
        bif.bus_rdata = 8'h00;
        bif.bus_wait_n = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("rst_rd_n", {31'd0, bif.bus_rd_n}, 1);
        check("rst_wr_n", {31'd0, bif.bus_wr_n}, 1);
        check("rst_addr", {16'd0, bif.bus_addr}, 0);
        check("rst_wdata", {24'd0, bif.bus_wdata}, 0);
        check("rst_rdata", {24'd0, bif.rsp_rdata}, 0);
        check("rst_valid", {31'd0, bif.rsp_valid}, 0);
        check("rst_err", {31'd0, bif.rsp_err}, 0);
        check("rst_busy", {31'd0, bif.busy}, 0);
        check("rst_ready", {31'd0, bif.req_ready}, 1);
        @(posedge clk);
        #1;

        issue(1'b0, 16'hC123, 8'h00, 8'h5A, 0, 1'b0, a1); wait_done();
        issue(1'b1, 16'hFF80, 8'hA5, 8'h00, 0, 1'b0, a1); wait_done();
        issue(1'b0, 16'h0150, 8'h00, 8'h3C, 3, 1'b0, a1); wait_done();
        issue(1'b0, 16'h1234, 8'h00, 8'h99, 100, 1'b0, a1); wait_done();
        issue(1'b0, 16'h2000, 8'h00, 8'h77, TO, 1'b0, a1); wait_done();
        issue(1'b1, 16'h8000, 8'h11, 8'h00, 100, 1'b0, a1); wait_done();

        issue(1'b1, 16'h9000, 8'h22, 8'h00, 0, 1'b1, a1);
        issue(1'b0, 16'h9001, 8'h5E, 8'h44, 0, 1'b0, a2);
        check("b2b_gap", a2 - a1, 5);
        wait_done();

        bif.req_we = 1'b1;
        bif.req_addr = 16'hFFFF;
        bif.req_wdata = 8'hEE;
        repeat (3) @(posedge clk);
        #1;
        check("idle_addr_hold", {16'd0, bif.bus_addr}, 32'h9001);
        check("idle_wdata_hold", {24'd0, bif.bus_wdata}, 32'h5E);
        check("idle_busy", {31'd0, bif.busy}, 0);

        issue(1'b1, 16'h4000, 8'h3E, 8'h00, 100, 1'b0, a1);
        repeat (6) @(posedge clk);
        check("wr_before_rst", {31'd0, bif.bus_wr_n}, 0);
        #3 rst_n = 1'b0;
        #1;
        check("rst_async_wr_n", {31'd0, bif.bus_wr_n}, 1);
        check("rst_async_busy", {31'd0, bif.busy}, 0);
        check("rst_async_valid", {31'd0, bif.rsp_valid}, 0);
        q.delete();
        model_rdata = 8'h00;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_ready", {31'd0, bif.req_ready}, 1);
        issue(1'b0, 16'hABCD, 8'h00, 8'hC7, 1, 1'b0, a1); wait_done();

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
